// File: rtl/addr_burst_issuer.sv
// addr_burst_issuer: queues {start address, length} commands in a small FIFO and
// expands each into a stream of consecutive beat addresses with valid/ready handshake.
module addr_burst_issuer #(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_count,
    input  logic [3:0]        in_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_last,
    output logic              busy,
    output logic [15:0]       beat_cnt,
    output logic              wrap_err
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic {IDLE, BURST} state_t;

    state_t            r_state, w_next;
    logic [ADDR_W+3:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wp, r_rp;
    logic [PW:0]       r_cnt;
    logic              r_up;
    logic [ADDR_W-1:0] r_base;
    logic [3:0]        r_idx, r_len;
    logic [15:0]       r_beats;
    logic              r_wrap;
    logic [ADDR_W+3:0] w_head;
    logic              w_push, w_pop, w_xfer, w_empty, w_full, w_last;

    assign w_empty   = (r_cnt == '0);
    assign w_full    = (r_cnt == (PW+1)'(DEPTH));
    // r_up keeps in_ready low until the first edge after reset release
    assign in_ready  = r_up && !w_full;
    assign w_push    = in_valid && in_ready;
    assign w_head    = r_mem[r_rp];
    assign w_last    = (r_idx == r_len);
    assign out_valid = (r_state == BURST);
    assign out_addr  = out_valid ? r_base + ADDR_W'(r_idx) : '0;
    assign out_last  = out_valid && w_last;
    assign w_xfer    = out_valid && out_ready;
    assign busy      = out_valid || !w_empty;
    assign beat_cnt  = r_beats;
    assign wrap_err  = r_wrap;

    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        if (r_state == IDLE) begin
            w_pop  = !w_empty;
            w_next = w_empty ? IDLE : BURST;
        end else if (w_xfer && w_last) begin
            // chain straight into the next queued burst so no idle beat appears
            w_pop  = !w_empty;
            w_next = w_empty ? IDLE : BURST;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wp] <= {in_count, in_len};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_wp    <= '0;
            r_rp    <= '0;
            r_cnt   <= '0;
            r_up    <= 1'b0;
            r_base  <= '0;
            r_idx   <= '0;
            r_len   <= '0;
            r_beats <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_up    <= 1'b1;
            r_state <= w_next;
            r_cnt   <= r_cnt + (PW+1)'(w_push) - (PW+1)'(w_pop);
            if (w_push) r_wp <= r_wp + 1'b1;
            if (w_pop) begin
                r_rp   <= r_rp + 1'b1;
                r_base <= w_head[ADDR_W+3:4];
                r_len  <= w_head[3:0];
                r_idx  <= '0;
            end else if (w_xfer && !w_last) begin
                r_idx  <= r_idx + 1'b1;
            end
            if (w_xfer) begin
                r_beats <= r_beats + 1'b1;
                if (r_idx != '0 && out_addr == '0) r_wrap <= 1'b1;
            end
        end
    end
endmodule
